// File: rtl/stage_memory.sv
// rtl/stage_memory.sv - memory-access pipeline stage with req/ack data port, stall, timeout and misalign detection
// Registers results into the memory->writeback pipeline register.
module stage_memory #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wb_clear,
    input  logic        mem_reg_write,
    input  logic        mem_mem_write,
    input  logic [1:0]  mem_result_src,
    input  logic [31:0] mem_alu_result,
    input  logic [31:0] mem_write_data,
    input  logic [31:0] mem_pc_plus_4,
    input  logic [31:0] mem_imm_ext,
    input  logic [4:0]  mem_rd,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic        mem_stall,
    output logic        mem_bus_error,
    output logic        mem_misaligned,
    output logic        wb_reg_write,
    output logic [1:0]  wb_result_src,
    output logic [31:0] wb_alu_result,
    output logic [31:0] wb_read_data,
    output logic [31:0] wb_pc_plus_4,
    output logic [31:0] wb_imm_ext,
    output logic [4:0]  wb_rd
);

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES);

    state_t      r_state;
    state_t      w_state_next;
    logic [7:0]  r_cnt;
    logic [7:0]  w_cnt_next;

    logic        w_is_store;
    logic        w_is_load;
    logic        w_access;
    logic        w_misaligned;
    logic        w_aligned;
    logic        w_req;
    logic        w_stall;
    logic        w_timeout;
    logic        w_ack;

    logic        r_bus_error;
    logic        r_misaligned;
    logic        r_wb_reg_write;
    logic [1:0]  r_wb_result_src;
    logic [31:0] r_wb_alu_result;
    logic [31:0] r_wb_read_data;
    logic [31:0] r_wb_pc_plus_4;
    logic [31:0] r_wb_imm_ext;
    logic [4:0]  r_wb_rd;

    // A store wins over a load when both are flagged.
    assign w_is_store   = mem_mem_write;
    assign w_is_load    = !mem_mem_write && (mem_result_src == 2'b01);
    assign w_access     = w_is_store || w_is_load;
    assign w_misaligned = w_access && (mem_alu_result[1:0] != 2'b00);
    assign w_aligned    = w_access && !w_misaligned;

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_req        = 1'b0;
        w_stall      = 1'b0;
        w_timeout    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_aligned) begin
                    w_req = 1'b1;
                    if (!dmem_ack) begin
                        w_stall      = 1'b1;
                        w_state_next = WAIT;
                        w_cnt_next   = 8'd1;
                    end
                end
            end
            WAIT: begin
                if (!w_aligned) begin
                    w_state_next = IDLE;
                    w_cnt_next   = 8'd0;
                end else if (r_cnt >= TIMEOUT_LIMIT) begin
                    // Abandon: request drops, so any ack this cycle is ignored.
                    w_timeout    = 1'b1;
                    w_state_next = IDLE;
                    w_cnt_next   = 8'd0;
                end else begin
                    w_req = 1'b1;
                    if (dmem_ack) begin
                        w_state_next = IDLE;
                        w_cnt_next   = 8'd0;
                    end else begin
                        w_stall    = 1'b1;
                        w_cnt_next = r_cnt + 8'd1;
                    end
                end
            end
            default: begin
                w_state_next = IDLE;
                w_cnt_next   = 8'd0;
            end
        endcase
    end

    assign w_ack = w_req && dmem_ack;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= 8'd0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bus_error  <= 1'b0;
            r_misaligned <= 1'b0;
        end else begin
            if (w_timeout) begin
                r_bus_error <= 1'b1;
            end
            if (w_misaligned) begin
                r_misaligned <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wb_reg_write  <= 1'b0;
            r_wb_result_src <= 2'b00;
            r_wb_alu_result <= 32'd0;
            r_wb_read_data  <= 32'd0;
            r_wb_pc_plus_4  <= 32'd0;
            r_wb_imm_ext    <= 32'd0;
            r_wb_rd         <= 5'd0;
        end else if (wb_clear || w_stall) begin
            r_wb_reg_write  <= 1'b0;
            r_wb_result_src <= 2'b00;
            r_wb_alu_result <= 32'd0;
            r_wb_read_data  <= 32'd0;
            r_wb_pc_plus_4  <= 32'd0;
            r_wb_imm_ext    <= 32'd0;
            r_wb_rd         <= 5'd0;
        end else begin
            r_wb_reg_write  <= mem_reg_write && !w_misaligned && !w_timeout;
            r_wb_result_src <= mem_result_src;
            r_wb_alu_result <= mem_alu_result;
            r_wb_read_data  <= (w_is_load && w_ack) ? dmem_rdata : 32'd0;
            r_wb_pc_plus_4  <= mem_pc_plus_4;
            r_wb_imm_ext    <= mem_imm_ext;
            r_wb_rd         <= mem_rd;
        end
    end

    // Combinational port outputs are forced quiet while reset is held.
    assign dmem_req   = rst_n && w_req;
    assign dmem_we    = dmem_req && w_is_store;
    assign dmem_addr  = dmem_req ? {mem_alu_result[31:2], 2'b00} : 32'd0;
    assign dmem_wdata = dmem_req ? mem_write_data : 32'd0;
    assign mem_stall  = rst_n && w_stall;

    assign mem_bus_error  = r_bus_error;
    assign mem_misaligned = r_misaligned;
    assign wb_reg_write   = r_wb_reg_write;
    assign wb_result_src  = r_wb_result_src;
    assign wb_alu_result  = r_wb_alu_result;
    assign wb_read_data   = r_wb_read_data;
    assign wb_pc_plus_4   = r_wb_pc_plus_4;
    assign wb_imm_ext     = r_wb_imm_ext;
    assign wb_rd          = r_wb_rd;

endmodule

// File: tb/tb_stage_memory.sv
// tb/tb_stage_memory.sv - directed self-checking bench for stage_memory
module tb_stage_memory;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wb_clear;
    logic        mem_reg_write;
    logic        mem_mem_write;
    logic [1:0]  mem_result_src;
    logic [31:0] mem_alu_result;
    logic [31:0] mem_write_data;
    logic [31:0] mem_pc_plus_4;
    logic [31:0] mem_imm_ext;
    logic [4:0]  mem_rd;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        dmem_ack;
    logic        mem_stall;
    logic        mem_bus_error;
    logic        mem_misaligned;
    logic        wb_reg_write;
    logic [1:0]  wb_result_src;
    logic [31:0] wb_alu_result;
    logic [31:0] wb_read_data;
    logic [31:0] wb_pc_plus_4;
    logic [31:0] wb_imm_ext;
    logic [4:0]  wb_rd;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    stage_memory #(.TIMEOUT_CYCLES(4)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .wb_clear       (wb_clear),
        .mem_reg_write  (mem_reg_write),
        .mem_mem_write  (mem_mem_write),
        .mem_result_src (mem_result_src),
        .mem_alu_result (mem_alu_result),
        .mem_write_data (mem_write_data),
        .mem_pc_plus_4  (mem_pc_plus_4),
        .mem_imm_ext    (mem_imm_ext),
        .mem_rd         (mem_rd),
        .dmem_req       (dmem_req),
        .dmem_we        (dmem_we),
        .dmem_addr      (dmem_addr),
        .dmem_wdata     (dmem_wdata),
        .dmem_rdata     (dmem_rdata),
        .dmem_ack       (dmem_ack),
        .mem_stall      (mem_stall),
        .mem_bus_error  (mem_bus_error),
        .mem_misaligned (mem_misaligned),
        .wb_reg_write   (wb_reg_write),
        .wb_result_src  (wb_result_src),
        .wb_alu_result  (wb_alu_result),
        .wb_read_data   (wb_read_data),
        .wb_pc_plus_4   (wb_pc_plus_4),
        .wb_imm_ext     (wb_imm_ext),
        .wb_rd          (wb_rd)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic instr(input logic rw, input logic mw, input logic [1:0] rs,
                         input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] rd);
        mem_reg_write  = rw;
        mem_mem_write  = mw;
        mem_result_src = rs;
        mem_alu_result = alu;
        mem_write_data = wd;
        mem_rd         = rd;
        mem_pc_plus_4  = alu + 32'd4;
        mem_imm_ext    = 32'h0000_0011;
    endtask

    task automatic chk_wb_zero(input string tag);
        chk({tag, "_wb_reg_write"}, 32'(wb_reg_write), 32'd0);
        chk({tag, "_wb_alu"}, wb_alu_result, 32'd0);
        chk({tag, "_wb_rdata"}, wb_read_data, 32'd0);
        chk({tag, "_wb_rd"}, 32'(wb_rd), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        wb_clear = 1'b0;
        dmem_ack = 1'b0;
        dmem_rdata = 32'd0;
        instr(1'b0, 1'b0, 2'b00, 32'd0, 32'd0, 5'd0);
        repeat (2) @(posedge clk);
        #1;
        chk_wb_zero("reset");
        chk("reset_req", 32'(dmem_req), 32'd0);
        chk("reset_stall", 32'(mem_stall), 32'd0);
        chk("reset_flags", {30'd0, mem_bus_error, mem_misaligned}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // ALU instruction
        instr(1'b1, 1'b0, 2'b00, 32'h1234, 32'd0, 5'd5);
        @(negedge clk);
        chk("alu_req", 32'(dmem_req), 32'd0);
        chk("alu_stall", 32'(mem_stall), 32'd0);
        tick();
        chk("alu_wb_alu", wb_alu_result, 32'h1234);
        chk("alu_wb_rd", 32'(wb_rd), 32'd5);
        chk("alu_wb_rw", 32'(wb_reg_write), 32'd1);
        chk("alu_wb_pc4", wb_pc_plus_4, 32'h1238);

        // Zero-wait load
        instr(1'b1, 1'b0, 2'b01, 32'h100, 32'd0, 5'd7);
        dmem_ack = 1'b1;
        dmem_rdata = 32'hCAFEF00D;
        @(negedge clk);
        chk("ld0_req", 32'(dmem_req), 32'd1);
        chk("ld0_we", 32'(dmem_we), 32'd0);
        chk("ld0_addr", dmem_addr, 32'h100);
        chk("ld0_stall", 32'(mem_stall), 32'd0);
        tick();
        chk("ld0_wb_rdata", wb_read_data, 32'hCAFEF00D);
        chk("ld0_wb_rw", 32'(wb_reg_write), 32'd1);
        chk("ld0_wb_rd", 32'(wb_rd), 32'd7);
        chk("ld0_wb_src", 32'(wb_result_src), 32'd1);

        // Store with 3 wait cycles
        instr(1'b0, 1'b1, 2'b00, 32'h200, 32'hA5A5A5A5, 5'd0);
        dmem_ack = 1'b0;
        dmem_rdata = 32'h5555_AAAA;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("st_stall%0d", i), 32'(mem_stall), 32'd1);
            chk($sformatf("st_req%0d", i), 32'(dmem_req), 32'd1);
            chk($sformatf("st_we%0d", i), 32'(dmem_we), 32'd1);
            chk($sformatf("st_addr%0d", i), dmem_addr, 32'h200);
            chk($sformatf("st_wdata%0d", i), dmem_wdata, 32'hA5A5A5A5);
            tick();
            chk($sformatf("st_bubble_alu%0d", i), wb_alu_result, 32'd0);
            chk($sformatf("st_bubble_pc4%0d", i), wb_pc_plus_4, 32'd0);
        end
        dmem_ack = 1'b1;
        @(negedge clk);
        chk("st_done_stall", 32'(mem_stall), 32'd0);
        chk("st_done_req", 32'(dmem_req), 32'd1);
        tick();
        dmem_ack = 1'b0;
        chk("st_wb_alu", wb_alu_result, 32'h200);
        chk("st_wb_rw", 32'(wb_reg_write), 32'd0);
        chk("st_wb_rdata", wb_read_data, 32'd0);

        // Load that times out after 4 stall cycles
        instr(1'b1, 1'b0, 2'b01, 32'h300, 32'd0, 5'd9);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("to_stall%0d", i), 32'(mem_stall), 32'd1);
            chk($sformatf("to_req%0d", i), 32'(dmem_req), 32'd1);
            tick();
        end
        chk("to_err_before", 32'(mem_bus_error), 32'd0);
        dmem_ack = 1'b1;
        dmem_rdata = 32'hDEADBEEF;
        @(negedge clk);
        chk("to_req_drop", 32'(dmem_req), 32'd0);
        chk("to_stall_drop", 32'(mem_stall), 32'd0);
        tick();
        dmem_ack = 1'b0;
        chk("to_bus_error", 32'(mem_bus_error), 32'd1);
        chk("to_wb_rw", 32'(wb_reg_write), 32'd0);
        chk("to_wb_rdata", wb_read_data, 32'd0);
        chk("to_wb_alu", wb_alu_result, 32'h300);

        // Misaligned load
        instr(1'b1, 1'b0, 2'b01, 32'h102, 32'd0, 5'd3);
        @(negedge clk);
        chk("mis_req", 32'(dmem_req), 32'd0);
        chk("mis_stall", 32'(mem_stall), 32'd0);
        tick();
        chk("mis_flag", 32'(mem_misaligned), 32'd1);
        chk("mis_wb_rw", 32'(wb_reg_write), 32'd0);
        chk("mis_wb_alu", wb_alu_result, 32'h102);
        chk("err_sticky", 32'(mem_bus_error), 32'd1);

        // wb_clear flushes a passing instruction
        instr(1'b1, 1'b0, 2'b00, 32'h77, 32'd0, 5'd4);
        wb_clear = 1'b1;
        tick();
        wb_clear = 1'b0;
        chk_wb_zero("clr");

        // Reset while waiting
        instr(1'b1, 1'b0, 2'b01, 32'h400, 32'd0, 5'd6);
        @(negedge clk);
        chk("rst_wait_stall", 32'(mem_stall), 32'd1);
        tick();
        rst_n = 1'b0;
        #1;
        chk("rst_req", 32'(dmem_req), 32'd0);
        chk("rst_stall", 32'(mem_stall), 32'd0);
        chk("rst_flags", {30'd0, mem_bus_error, mem_misaligned}, 32'd0);
        chk_wb_zero("rst");
        instr(1'b0, 1'b0, 2'b00, 32'd0, 32'd0, 5'd0);
        dmem_ack = 1'b1;
        dmem_rdata = 32'h1111_2222;
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_req", 32'(dmem_req), 32'd0);
        chk("post_rst_stall", 32'(mem_stall), 32'd0);
        tick();
        dmem_ack = 1'b0;
        chk("post_rst_rdata", wb_read_data, 32'd0);
        chk("post_rst_rw", 32'(wb_reg_write), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/stage_memory.md
# stage_memory

Memory-access pipeline stage directly downstream of the execute stage. It consumes the execute→memory pipeline register, performs load/store transactions on a variable-latency data-memory port with a req/ack handshake, and stalls the pipeline while a transaction is outstanding. It also flags misaligned accesses and bus timeouts, and registers results into the memory→writeback pipeline register.

## Interface
Parameters:
- TIMEOUT_CYCLES, 16: number of wait cycles without `dmem_ack` before the access is abandoned. Legal range is 1..255.

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- wb_clear  in  1  synchronous flush of the writeback register (from the hazard unit)
- mem_reg_write  in  1  instruction writes the register file
- mem_mem_write  in  1  instruction is a store
- mem_result_src  in  2  result select: 00 ALU, 01 load data, 10 pc+4, 11 imm; 01 marks a load
- mem_alu_result  in  32  byte address for a load/store, or the ALU result
- mem_write_data  in  32  store data
- mem_pc_plus_4  in  32  link value
- mem_imm_ext  in  32  immediate
- mem_rd  in  5  destination register
- dmem_req  out  1  access request
- dmem_we  out  1  1 = write
- dmem_addr  out  32  word-aligned byte address
- dmem_wdata  out  32  store data
- dmem_rdata  in  32  read data, valid when `dmem_ack` is high
- dmem_ack  in  1  transaction complete
- mem_stall  out  1  freeze all upstream pipeline registers and the PC
- mem_bus_error  out  1  sticky: a timeout occurred
- mem_misaligned  out  1  sticky: an access with `addr[1:0]` ≠ 0 occurred
- wb_reg_write  out  1  registered
- wb_result_src  out  2  registered
- wb_alu_result  out  32  registered
- wb_read_data  out  32  registered
- wb_pc_plus_4  out  32  registered
- wb_imm_ext  out  32  registered
- wb_rd  out  5  registered

## Operation
- An access occurs when `mem_mem_write` = 1 or `mem_result_src` = 01. A store takes precedence if both are set.
- Misaligned accesses (`mem_alu_result[1:0]` ≠ 0):
  - No request is issued and no stall occurs.
  - `mem_misaligned` is set.
  - The instruction passes to writeback with `wb_reg_write` = 0.
- The FSM has two states, IDLE and WAIT.
- IDLE with an aligned access:
  - `dmem_req` = 1 combinationally, with `dmem_we` = store, `dmem_addr` = `mem_alu_result`, `dmem_wdata` = `mem_write_data`.
  - If `dmem_ack` arrives in the same cycle, the access completes with zero wait; the state stays IDLE and `mem_stall` = 0.
  - Otherwise `mem_stall` = 1 and the FSM moves to WAIT with wait counter = 1.
- WAIT:
  - `dmem_req` stays at 1 with identical `we`/`addr`/`wdata`; upstream holds its inputs because of the stall.
  - `mem_stall` = 1 except in the completing cycle.
  - If `dmem_ack` = 1: the access completes, `mem_stall` = 0, and the FSM returns to IDLE.
  - If the counter reaches TIMEOUT_CYCLES without an ack:
    - The access is abandoned and `dmem_req` drops.
    - `mem_bus_error` is set.
    - The instruction completes with `wb_read_data` = 0 and `wb_reg_write` = 0.
    - `mem_stall` = 0 in that cycle and the FSM returns to IDLE.
  - Otherwise the counter increments.
- `dmem_ack` is ignored in any cycle where `dmem_req` = 0.
- Non-access instructions pass through in a single cycle and never stall.
- Writeback register update each rising edge:
  - `wb_clear` = 1 → all `wb_*` outputs are set to 0.
  - Else `mem_stall` = 1 → a bubble is inserted: all `wb_*` outputs are set to 0.
  - Else all `wb_*` outputs take the `mem_*` inputs. `wb_read_data` = `dmem_rdata` on a completing load, otherwise 0.
- `wb_clear` does not abort an outstanding access; the FSM continues.
- Sticky flags clear only on reset.

## Timing
- Reset (asynchronous, `rst_n` = 0):
  - FSM goes to IDLE and the counter to 0.
  - All `wb_*` outputs = 0.
  - `mem_bus_error` = `mem_misaligned` = 0.
  - `dmem_req` = 0 and `mem_stall` = 0, because the combinational outputs are gated by `rst_n`.
  - Reset during WAIT abandons the access with no writeback.
- Latency:
  - A non-access instruction, or a zero-wait access, appears on `wb_*` one edge after it is presented.
  - An access acked after N wait cycles appears at edge N+1; `mem_stall` is high for N cycles.
- Timeout: `mem_stall` is high for exactly TIMEOUT_CYCLES cycles, then completes in the following cycle.
- Back-to-back accesses: after a completion the next instruction is presented on the next edge and re-enters IDLE, so there are no dead cycles.

## Test plan
- ALU instruction (`result_src` = 00, `rd` = 5, `alu` = 0x1234) → next edge: `wb_alu_result` = 0x1234, `wb_rd` = 5, `wb_reg_write` = 1, `dmem_req` never high.
- Load from 0x100 with ack in the same cycle, `rdata` = 0xCAFEF00D → `mem_stall` stays 0; next edge `wb_read_data` = 0xCAFEF00D.
- Store to 0x200, `wdata` = 0xA5A5A5A5, ack after 3 wait cycles:
  - `mem_stall` is high for 3 cycles while `req`/`addr`/`we` stay stable.
  - `wb_*` holds bubbles during the wait, then the store appears with `wb_reg_write` = 0.
- Load from 0x300 with no ack and TIMEOUT_CYCLES = 4:
  - Stall lasts 4 cycles, then `dmem_req` drops.
  - `mem_bus_error` = 1 and stays at 1.
  - `wb_reg_write` = 0 and `wb_read_data` = 0.
- Load from 0x102 → no request, no stall, `mem_misaligned` = 1, `wb_reg_write` = 0.
- Load in WAIT, then `rst_n` pulses low for 1 cycle → immediately `dmem_req` = 0 and all outputs = 0; a later ack is ignored.
